// File: rtl/snn_pkg.sv
// Shared types for the SNN timestep sequencer.
// SNN_SEQ_WDUMP_EN adds the weight-dump state.
package snn_pkg;

  localparam int W_WIDTH = 16;

  typedef logic signed [W_WIDTH-1:0] weight_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STEP,
    S_SAMPLE,
    S_EMIT,
    S_LEARN,
    S_GAP,
`ifdef SNN_SEQ_WDUMP_EN
    S_DUMP,
`endif
    S_FIN
  } seq_state_e;

endpackage

// File: rtl/snn_step_sequencer_if.sv
// Spike-row stream: one latched row per timestep,
// tagged with its timestep index.
interface snn_step_sequencer_if #(
  parameter int N    = 96,
  parameter int EVAW = 10
);
  logic            valid;
  logic            ready;
  logic [N-1:0]    data;
  logic [EVAW-1:0] t;

  modport master (
    output valid, data, t,
    input  ready
  );

  modport slave (
    input  valid, data, t,
    output ready
  );
endinterface

// File: rtl/snn_seq_wdump.sv
// Weight readback streamer: walks addr 0..M-1 through a
// 1-cycle-latency RAM into a 2-entry skid for backpressure.
module snn_seq_wdump
  import snn_pkg::*;
#(
  parameter int M  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  output logic [AW-1:0] o_rb_addr,
  input  weight_t       i_rb_data,
  output logic          o_valid,
  input  logic          i_ready,
  output weight_t       o_data,
  output logic          o_last
);

  logic [AW:0] r_addr;
  logic        r_pend;
  logic        r_pend_last;
  weight_t     r_buf [2];
  logic [1:0]  r_blast;
  logic        r_rd;
  logic        r_wr;
  logic [1:0]  r_cnt;
  logic        w_pop;
  logic        w_issue;
  logic [2:0]  w_used;
  logic [2:0]  w_room;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_buf[r_rd];
  assign o_last  = r_blast[r_rd];
  assign w_pop   = o_valid & i_ready;

  // Held words plus the read in flight must fit in the skid.
  assign w_used  = {1'b0, r_cnt} + {2'b0, r_pend};
  assign w_room  = 3'd2 + {2'b0, w_pop};
  assign w_issue = !i_clr
                 && (r_addr < (AW+1)'(M))
                 && (w_used < w_room);

  assign o_rb_addr = w_issue ? r_addr[AW-1:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_blast     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
    end else if (i_clr) begin
      r_addr      <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_pend      <= w_issue;
      r_pend_last <= w_issue
                   && (r_addr == (AW+1)'(M-1));
      if (w_issue) r_addr <= r_addr + 1'b1;
      if (r_pend) begin
        r_buf[r_wr]   <= i_rb_data;
        r_blast[r_wr] <= r_pend_last;
        r_wr          <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt
             + {1'b0, r_pend}
             - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/snn_step_sequencer.sv
// Timestep controller for snn_core: fetch, step, emit, optional STDP.
// SNN_SEQ_WDUMP_EN enables the post-learning weight dump.
module snn_step_sequencer
  import snn_pkg::*;
#(
  parameter int F        = 48,
  parameter int N        = 96,
  parameter int EV_DEPTH = 1024,
  parameter int EVAW     = $clog2(EV_DEPTH),
  parameter int AW       = $clog2(F*N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [EVAW:0]        cfg_T,
  input  logic [7:0]           cfg_epochs,
  input  logic                 cfg_learn,
  output logic                 busy,
  output logic                 done,
  output logic [EVAW-1:0]      ev_addr,
  input  logic [F-1:0]         ev_data,
  output logic [F-1:0]         event_vec,
  output logic                 core_step,
  input  logic [N-1:0]         spikes_vec,
  output logic                 stdp_enable,
  output logic [F-1:0]         stdp_pre_bits,
  output logic [N-1:0]         stdp_post_bits,
  snn_step_sequencer_if.master spk,
  output logic [AW-1:0]        rb_addr,
  input  weight_t              rb_data,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output weight_t              wb_data,
  output logic                 wb_last
);

  localparam int M = F * N;
  localparam logic [AW-1:0] K_LAST = AW'(M - 1);

  seq_state_e      r_state;
  seq_state_e      w_next;
  seq_state_e      w_after;
  logic [EVAW:0]   r_T;
  logic [7:0]      r_ep_tot;
  logic            r_learn;
  logic [EVAW-1:0] r_t;
  logic [AW-1:0]   r_k;
  logic [7:0]      r_epoch;
  logic [F-1:0]    r_ev;
  logic [N-1:0]    r_spk;
  logic [EVAW-1:0] r_spk_t;
  logic            w_last_t;
  logic            w_more_ep;
  logic            w_step_done;
  logic            w_wb_fin;

  assign w_last_t    = ({1'b0, r_t} == r_T - 1'b1);
  assign w_more_ep   = (r_epoch + 8'd1) < r_ep_tot;
  assign w_step_done = (r_state == S_EMIT && spk.ready && !r_learn)
                    || (r_state == S_GAP);

  always_comb begin
    w_after = S_FIN;
    if (!w_last_t || w_more_ep) w_after = S_FETCH;
`ifdef SNN_SEQ_WDUMP_EN
    else if (r_learn) w_after = S_DUMP;
`endif
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = (cfg_T == '0) ? S_FIN : S_FETCH;
      S_FETCH:  w_next = S_LOAD;
      S_LOAD:   w_next = S_STEP;
      S_STEP:   w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_EMIT;
      S_EMIT:   if (spk.ready) w_next = r_learn ? S_LEARN : w_after;
      S_LEARN:  if (r_k == K_LAST) w_next = S_GAP;
      S_GAP:    w_next = w_after;
`ifdef SNN_SEQ_WDUMP_EN
      S_DUMP:   if (w_wb_fin) w_next = S_FIN;
`endif
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_T      <= '0;
      r_ep_tot <= '0;
      r_learn  <= 1'b0;
      r_t      <= '0;
      r_k      <= '0;
      r_epoch  <= '0;
      r_ev     <= '0;
      r_spk    <= '0;
      r_spk_t  <= '0;
    end else begin
      r_state <= w_next;
      if (abort || w_next == S_FIN) r_ev <= '0;
      else if (r_state == S_LOAD) r_ev <= ev_data;
      if (!abort) begin
        if (r_state == S_IDLE && start) begin
          r_T      <= cfg_T;
          r_ep_tot <= (cfg_epochs == 8'd0) ? 8'd1 : cfg_epochs;
          r_learn  <= cfg_learn;
          r_t      <= '0;
          r_k      <= '0;
          r_epoch  <= '0;
        end
        if (r_state == S_SAMPLE) begin
          r_spk   <= spikes_vec;
          r_spk_t <= r_t;
        end
        if (r_state == S_LEARN && r_k != K_LAST) r_k <= r_k + 1'b1;
        // t and epoch hold at their terminal values after the last step.
        if (w_step_done) begin
          r_k <= '0;
          if (!w_last_t) r_t <= r_t + 1'b1;
          else begin
            if (r_epoch != r_ep_tot) r_epoch <= r_epoch + 8'd1;
            if (w_more_ep) r_t <= '0;
          end
        end
      end
    end
  end

  assign busy           = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done           = (r_state == S_FIN);
  assign ev_addr        = r_t;
  assign event_vec      = r_ev;
  assign core_step      = (r_state == S_STEP);
  assign stdp_enable    = (r_state == S_LEARN);
  assign stdp_pre_bits  = r_ev;
  assign stdp_post_bits = r_spk;
  assign spk.valid      = (r_state == S_EMIT);
  assign spk.data       = r_spk;
  assign spk.t          = r_spk_t;

`ifdef SNN_SEQ_WDUMP_EN
  snn_seq_wdump #(
    .M  (M),
    .AW (AW)
  ) u_wdump (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     ((r_state != S_DUMP) || abort),
    .o_rb_addr (rb_addr),
    .i_rb_data (rb_data),
    .o_valid   (wb_valid),
    .i_ready   (wb_ready),
    .o_data    (wb_data),
    .o_last    (wb_last)
  );
  assign w_wb_fin = wb_valid & wb_ready & wb_last;
`else
  logic w_unused;
  assign w_unused = ^{rb_data, wb_ready};
  assign w_wb_fin = 1'b0;
  assign rb_addr  = '0;
  assign wb_valid = 1'b0;
  assign wb_data  = '0;
  assign wb_last  = 1'b0;
`endif

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Directed bench for snn_step_sequencer (F=4, N=2, 16-deep event RAM).
// Covers inference, epochs, STDP, backpressure, cfg_T=0, abort, dump.
module tb_snn_step_sequencer;
  import snn_pkg::*;

  localparam int F = 4;
  localparam int N = 2;
  localparam int EVD = 16;
  localparam int EVAW = 4;
  localparam int AW = 3;
  localparam logic [1:0] ROW [4] = '{2'd1, 2'd3, 2'd3, 2'd1};
  localparam logic [15:0] WRAM [8] = '{16'h0011, 16'hFFEE, 16'h1234,
    16'h8000, 16'h7FFF, 16'h0000, 16'h00A5, 16'hC3C3};
`ifdef SNN_SEQ_WDUMP_EN
  localparam int LEARN_N = 39;
`else
  localparam int LEARN_N = 29;
`endif

  logic clk = 0, rstn = 0, start = 0, abort = 0;
  logic [EVAW:0] cfg_T = '0;
  logic [7:0] cfg_epochs = '0;
  logic cfg_learn = 0;
  logic busy, done, core_step, stdp_enable;
  logic [EVAW-1:0] ev_addr;
  logic [F-1:0] ev_data = '0, event_vec, pre;
  logic [N-1:0] spikes_vec = '0, post;
  logic [AW-1:0] rb_addr;
  weight_t rb_data = '0, wb_data;
  logic wb_valid, wb_ready = 1, wb_last;
  logic [3:0] evram [EVD];

  snn_step_sequencer_if #(.N(N), .EVAW(EVAW)) spk_if ();

  snn_step_sequencer #(.F(F), .N(N), .EV_DEPTH(EVD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_T(cfg_T), .cfg_epochs(cfg_epochs), .cfg_learn(cfg_learn),
    .busy(busy), .done(done), .ev_addr(ev_addr), .ev_data(ev_data),
    .event_vec(event_vec), .core_step(core_step),
    .spikes_vec(spikes_vec), .stdp_enable(stdp_enable),
    .stdp_pre_bits(pre), .stdp_post_bits(post), .spk(spk_if),
    .rb_addr(rb_addr), .rb_data(rb_data), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ev_data <= evram[ev_addr];
  always @(posedge clk)
    spikes_vec <= core_step ? (event_vec[1:0] ^ event_vec[3:2]) : 2'b00;
  always @(posedge clk) rb_data <= WRAM[rb_addr];

  int n_chk = 0, n_pass = 0;
  logic mon_clr = 0;
  int n_step, n_rows, n_done, n_runs, run_len, min_run, max_run;
  int n_unstable, n_wb;
  logic wb_seen;
  logic [1:0] rows_d [16];
  logic [3:0] rows_t [16];
  logic [15:0] wb_d [16];
  logic wb_l [16];
  logic [3:0] pre0;
  logic [1:0] post0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_step <= 0; n_rows <= 0; n_done <= 0; n_runs <= 0;
      run_len <= 0; min_run <= 999; max_run <= 0;
      n_unstable <= 0; n_wb <= 0; wb_seen <= 0;
    end else begin
      if (core_step) n_step <= n_step + 1;
      if (done) n_done <= n_done + 1;
      if (spk_if.valid && spk_if.ready) begin
        if (n_rows < 16) begin
          rows_d[n_rows] <= spk_if.data;
          rows_t[n_rows] <= spk_if.t;
        end
        n_rows <= n_rows + 1;
      end
      if (stdp_enable) begin
        if (run_len == 0) begin
          pre0 <= pre; post0 <= post;
        end else if (pre !== pre0 || post !== post0)
          n_unstable <= n_unstable + 1;
        run_len <= run_len + 1;
      end else if (run_len > 0) begin
        n_runs <= n_runs + 1;
        if (run_len < min_run) min_run <= run_len;
        if (run_len > max_run) max_run <= run_len;
        run_len <= 0;
      end
      if (wb_valid) wb_seen <= 1;
      if (wb_valid && wb_ready) begin
        if (n_wb < 16) begin
          wb_d[n_wb] <= wb_data;
          wb_l[n_wb] <= wb_last;
        end
        n_wb <= n_wb + 1;
      end
    end
  end

  task clr_mon;
    mon_clr = 1;
    @(negedge clk);
    #1 mon_clr = 0;
  endtask

  task start_run(input int t, input int ep, input logic lrn);
    @(negedge clk);
    cfg_T = 5'(t); cfg_epochs = 8'(ep); cfg_learn = lrn;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task wait_done(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) n = -1;
    #1;
  endtask

  task test_reset;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, core_step, stdp_enable, spk_if.valid} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000",
        {busy, done, core_step, stdp_enable, spk_if.valid});
    else n_pass++;
    n_chk++;
    if (event_vec !== 4'h0) $display("FAIL reset_ev got %h want 0", event_vec);
    else n_pass++;
    n_chk++;
    if (ev_addr !== 4'h0) $display("FAIL reset_addr got %h want 0", ev_addr);
    else n_pass++;
    n_chk++;
    if ({wb_valid, wb_last, rb_addr} !== 5'b0)
      $display("FAIL reset_wb got %b want 0", {wb_valid, wb_last, rb_addr});
    else n_pass++;
    rstn = 1;
  endtask

  task test_infer;
    int n;
    clr_mon;
    start_run(4, 1, 0);
    wait_done(n);
    n_chk++;
    if (n !== 21) $display("FAIL infer_cycles got %0d want 21", n);
    else n_pass++;
    n_chk++;
    if ({busy, event_vec} !== 5'b0)
      $display("FAIL infer_fin got %b want 00000", {busy, event_vec});
    else n_pass++;
    n_chk++;
    if (n_rows !== 4 || n_step !== 4)
      $display("FAIL infer_counts got %0d/%0d want 4/4", n_rows, n_step);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({rows_d[i], rows_t[i]} !== {ROW[i], 4'(i)})
        $display("FAIL infer_row%0d got %h/%0d want %h/%0d",
          i, rows_d[i], rows_t[i], ROW[i], i);
      else n_pass++;
    end
    n_chk++;
    if (n_done !== 1) $display("FAIL infer_done_cnt got %0d want 1", n_done);
    else n_pass++;
  endtask

  task test_epochs;
    int n;
    clr_mon;
    start_run(2, 2, 0);
    wait_done(n);
    n_chk++;
    if (n !== 21) $display("FAIL epoch_cycles got %0d want 21", n);
    else n_pass++;
    n_chk++;
    if (n_rows !== 4) $display("FAIL epoch_rows got %0d want 4", n_rows);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({rows_d[i], rows_t[i]} !== {ROW[i % 2], 4'(i % 2)})
        $display("FAIL epoch_row%0d got %h/%0d want %h/%0d",
          i, rows_d[i], rows_t[i], ROW[i % 2], i % 2);
      else n_pass++;
    end
  endtask

  task test_learn;
    int n;
    clr_mon;
    start_run(2, 0, 1);
    wait_done(n);
    n_chk++;
    if (n !== LEARN_N) $display("FAIL learn_cycles got %0d want %0d", n, LEARN_N);
    else n_pass++;
    n_chk++;
    if (n_runs !== 2) $display("FAIL learn_runs got %0d want 2", n_runs);
    else n_pass++;
    n_chk++;
    if (min_run !== 8 || max_run !== 8)
      $display("FAIL learn_len got %0d..%0d want 8..8", min_run, max_run);
    else n_pass++;
    n_chk++;
    if (n_unstable !== 0) $display("FAIL learn_stable got %0d want 0", n_unstable);
    else n_pass++;
    n_chk++;
    if ({pre0, post0} !== {4'h6, 2'd3})
      $display("FAIL learn_bits got %h/%h want 6/3", pre0, post0);
    else n_pass++;
    n_chk++;
    if (n_rows !== 2) $display("FAIL learn_rows got %0d want 2", n_rows);
    else n_pass++;
`ifndef SNN_SEQ_WDUMP_EN
    n_chk++;
    if (wb_seen !== 1'b0) $display("FAIL learn_nowb got %b want 0", wb_seen);
    else n_pass++;
`endif
  endtask

  task test_backpressure;
    int n, c;
    clr_mon;
    start_run(3, 1, 0);
    c = 0;
    for (int i = 0; i < 100 && c < 2; i++) begin
      @(negedge clk);
      if (core_step) c++;
    end
    spk_if.ready = 0;
    for (int i = 0; i < 20 && !spk_if.valid; i++) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      n_chk++;
      if ({spk_if.valid, spk_if.data, spk_if.t, core_step} !== 8'b1_11_0001_0)
        $display("FAIL bp_hold%0d got %b want 11100010", j,
          {spk_if.valid, spk_if.data, spk_if.t, core_step});
      else n_pass++;
    end
    @(posedge clk);
    #1 spk_if.ready = 1;
    wait_done(n);
    n_chk++;
    if (n_rows !== 3 || n_step !== 3 || n < 0)
      $display("FAIL bp_counts got %0d/%0d want 3/3", n_rows, n_step);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({rows_d[i], rows_t[i]} !== {ROW[i], 4'(i)})
        $display("FAIL bp_row%0d got %h/%0d want %h/%0d",
          i, rows_d[i], rows_t[i], ROW[i], i);
      else n_pass++;
    end
  endtask

  task test_zero_t;
    int n;
    clr_mon;
    start_run(0, 1, 0);
    wait_done(n);
    n_chk++;
    if (n !== 1) $display("FAIL zero_cycles got %0d want 1", n);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (n_step !== 0 || n_rows !== 0)
      $display("FAIL zero_steps got %0d/%0d want 0/0", n_step, n_rows);
    else n_pass++;
  endtask

  task test_abort;
    int n, c;
    clr_mon;
    start_run(2, 1, 1);
    c = 0;
    for (int i = 0; i < 100 && c < 4; i++) begin
      @(negedge clk);
      if (stdp_enable) c++;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    n_chk++;
    if ({busy, stdp_enable, done, spk_if.valid, event_vec} !== 8'b0)
      $display("FAIL abort_idle got %b want 0",
        {busy, stdp_enable, done, spk_if.valid, event_vec});
    else n_pass++;
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if (n_done !== 0) $display("FAIL abort_nodone got %0d want 0", n_done);
    else n_pass++;
    @(negedge clk);
    cfg_T = 5'd4; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL abort_wins got %b want 0", busy);
    else n_pass++;
    clr_mon;
    start_run(4, 1, 0);
    wait_done(n);
    n_chk++;
    if (n !== 21 || n_rows !== 4)
      $display("FAIL abort_restart got %0d/%0d want 21/4", n, n_rows);
    else n_pass++;
    n_chk++;
    if ({rows_d[3], rows_t[3]} !== {ROW[3], 4'd3})
      $display("FAIL abort_lastrow got %h/%0d want %h/3",
        rows_d[3], rows_t[3], ROW[3]);
    else n_pass++;
  endtask

`ifdef SNN_SEQ_WDUMP_EN
  task test_wdump;
    clr_mon;
    start_run(1, 1, 1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 wb_ready = (i % 3) != 1;
      @(negedge clk);
      if (done) break;
    end
    wb_ready = 1;
    #1;
    n_chk++;
    if (n_wb !== 8 || n_done !== 1)
      $display("FAIL wd_count got %0d/%0d want 8/1", n_wb, n_done);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if ({wb_d[i], wb_l[i]} !== {WRAM[i], i == 7})
        $display("FAIL wd_word%0d got %h/%b want %h/%b",
          i, wb_d[i], wb_l[i], WRAM[i], i == 7);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < EVD; i++) evram[i] = 4'h0;
    evram[0] = 4'h1; evram[1] = 4'h6; evram[2] = 4'h9; evram[3] = 4'hE;
    spk_if.ready = 1;
    test_reset;
    test_infer;
    test_epochs;
    test_learn;
    test_backpressure;
    test_zero_t;
    test_abort;
`ifdef SNN_SEQ_WDUMP_EN
    test_wdump;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
